bgr_seq_ctrl: RTL and testbench



---
 rtl/bgr_ctrl_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/bgr_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bgr_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bgr_ctrl_pkg.sv
// Shared types and constants for the bandgap reference sequencer.
// State encoding is fixed because it is exported on debug pins.
package bgr_ctrl_pkg;

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_KICK   = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_READY  = 3'd4,
      S_FAULT  = 3'd5
   } bgr_state_e;

   localparam int TRIM_W = 4;
   localparam logic [TRIM_W-1:0] TRIM_RESET = 4'b1000;

   localparam int KICK_CYCLES_DEF   = 16;
   localparam int SETTLE_CYCLES_DEF = 1024;
   localparam int CHECK_CYCLES_DEF  = 256;
   localparam int DEBOUNCE_DEF      = 8;
   localparam int MAX_RETRY_DEF     = 3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous comparator flag.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/bgr_seq_ctrl.sv
// Bandgap reference power-up sequencer: kick, settle, qualify,
// retry/fault handling and safe application of the trim word.
module bgr_seq_ctrl
   import bgr_ctrl_pkg::*;
#(
   parameter int KICK_CYCLES   = KICK_CYCLES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int CHECK_CYCLES  = CHECK_CYCLES_DEF,
   parameter int DEBOUNCE      = DEBOUNCE_DEF,
   parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_req,
   input  logic [TRIM_W-1:0] trim_in,
   input  logic              trim_load,
   input  logic              cmp_ok,
   output logic              bgr_en,
   output logic              bgr_start,
   output logic [TRIM_W-1:0] trim_out,
   output logic              ready,
   output logic              fault,
   output logic [2:0]        state
);

   localparam logic [2:0] ST_OFF    = S_OFF;
   localparam logic [2:0] ST_KICK   = S_KICK;
   localparam logic [2:0] ST_SETTLE = S_SETTLE;
   localparam logic [2:0] ST_CHECK  = S_CHECK;
   localparam logic [2:0] ST_READY  = S_READY;
   localparam logic [2:0] ST_FAULT  = S_FAULT;

   localparam int CMAX = max3(KICK_CYCLES, SETTLE_CYCLES, CHECK_CYCLES);
   localparam int CW   = $clog2(CMAX + 1);
   localparam int DW   = $clog2(DEBOUNCE + 1);
   localparam int RW   = $clog2(MAX_RETRY + 1);

   localparam logic [CW-1:0] KICK_LAST   = CW'(KICK_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_CYCLES - 1);
   localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);
   localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

   logic              cmp_s;
   logic [2:0]        state_q, st_n;
   logic [CW-1:0]     cnt_q, cnt_n;
   logic [DW-1:0]     deb_q, deb_n, deb_inc;
   logic [DW-1:0]     loss_q, loss_n, loss_inc;
   logic [RW-1:0]     retry_q, retry_n, retry_inc;
   logic [TRIM_W-1:0] shadow_q, trim_q, trim_n;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cmp_ok),
      .q     (cmp_s)
   );

   assign deb_inc   = (deb_q == DEB_MAX) ? deb_q : deb_q + DW'(1);
   assign loss_inc  = (loss_q == DEB_MAX) ? loss_q : loss_q + DW'(1);
   assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);

   always_comb begin
      st_n    = state_q;
      cnt_n   = cnt_q;
      deb_n   = '0;
      loss_n  = '0;
      retry_n = retry_q;
      trim_n  = (state_q == ST_OFF) ? shadow_q : trim_q;
      if (!en_req) begin
         st_n    = ST_OFF;
         cnt_n   = '0;
         retry_n = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               st_n    = ST_KICK;
               cnt_n   = '0;
               retry_n = '0;
            end
            ST_KICK: begin
               if (cnt_q == KICK_LAST) begin
                  st_n  = ST_SETTLE;
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  st_n  = ST_CHECK;
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
            ST_CHECK: begin
               deb_n = cmp_s ? deb_inc : '0;
               // qualification beats a coincident timeout
               if (deb_n == DEB_MAX) begin
                  st_n    = ST_READY;
                  cnt_n   = '0;
                  retry_n = '0;
               end else if (cnt_q == CHECK_LAST) begin
                  cnt_n   = '0;
                  retry_n = retry_inc;
                  st_n    = (retry_inc < RETRY_MAX) ? ST_KICK : ST_FAULT;
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
            ST_READY: begin
               if (trim_load) begin
                  trim_n = trim_in;
                  st_n   = ST_SETTLE;
                  cnt_n  = '0;
               end else begin
                  loss_n = cmp_s ? '0 : loss_inc;
                  if (loss_n == DEB_MAX) begin
                     retry_n = retry_inc;
                     st_n    = (retry_q == RETRY_LAST) ? ST_FAULT : ST_KICK;
                     cnt_n   = '0;
                  end
               end
            end
            ST_FAULT: st_n = ST_FAULT;
            default: begin
               st_n  = ST_OFF;
               cnt_n = '0;
            end
         endcase
      end
      if (st_n != state_q) begin
         deb_n  = '0;
         loss_n = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_OFF;
         cnt_q     <= '0;
         deb_q     <= '0;
         loss_q    <= '0;
         retry_q   <= '0;
         shadow_q  <= TRIM_RESET;
         trim_q    <= TRIM_RESET;
         bgr_en    <= 1'b0;
         bgr_start <= 1'b0;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state_q   <= st_n;
         cnt_q     <= cnt_n;
         deb_q     <= deb_n;
         loss_q    <= loss_n;
         retry_q   <= retry_n;
         shadow_q  <= trim_load ? trim_in : shadow_q;
         trim_q    <= trim_n;
         bgr_en    <= (st_n == ST_KICK) || (st_n == ST_SETTLE) ||
                      (st_n == ST_CHECK) || (st_n == ST_READY);
         bgr_start <= (st_n == ST_KICK);
         ready     <= (st_n == ST_READY);
         fault     <= (st_n == ST_FAULT);
      end
   end

   assign state    = state_q;
   assign trim_out = trim_q;

endmodule

// File: tb/tb_bgr_seq_ctrl.sv
// Directed bench for bgr_seq_ctrl: phase table plus hand-written
// sequences for retries, glitch rejection and asynchronous reset.
module tb_bgr_seq_ctrl;

   localparam logic [2:0] OFF    = 3'd0;
   localparam logic [2:0] KICK   = 3'd1;
   localparam logic [2:0] SETTLE = 3'd2;
   localparam logic [2:0] CHECK  = 3'd3;
   localparam logic [2:0] READY  = 3'd4;
   localparam logic [2:0] FAULT  = 3'd5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_req;
   logic [3:0] trim_in;
   logic       trim_load;
   logic       cmp_ok;
   logic       bgr_en;
   logic       bgr_start;
   logic [3:0] trim_out;
   logic       ready;
   logic       fault;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bgr_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_req    (en_req),
      .trim_in   (trim_in),
      .trim_load (trim_load),
      .cmp_ok    (cmp_ok),
      .bgr_en    (bgr_en),
      .bgr_start (bgr_start),
      .trim_out  (trim_out),
      .ready     (ready),
      .fault     (fault),
      .state     (state)
   );

   typedef struct {
      logic       en;
      logic       cmp;
      logic       tl;
      logic [3:0] ti;
      int         n;
      logic [2:0] st;
      logic       be;
      logic       bs;
      logic       rdy;
      logic       flt;
      logic [3:0] tr;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t mk(
      input logic en, input logic cmp, input logic tl,
      input logic [3:0] ti, input int n, input logic [2:0] st,
      input logic be, input logic bs, input logic rdy,
      input logic flt, input logic [3:0] tr);
      vec_t v;
      v.en = en; v.cmp = cmp; v.tl = tl; v.ti = ti; v.n = n;
      v.st = st; v.be = be; v.bs = bs; v.rdy = rdy;
      v.flt = flt; v.tr = tr;
      return v;
   endfunction

   function automatic void chk(input string nm,
                               input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget,
                             output int n);
      n = 0;
      while (state !== s && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      en_req    = 1'b0;
      trim_load = 1'b0;
      trim_in   = 4'h0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int n, cyc, pulses, plen, bad_len;
      bit done, saw_rdy, early_flt, trim_bad;

      // clean power-up, trim in READY, loss of window, abort, OFF trim
      tab.push_back(mk(0,1,0,4'h0,   2, OFF,   0,0,0,0,4'h8));
      tab.push_back(mk(1,1,0,4'h0,   1, KICK,  1,1,0,0,4'h8));
      tab.push_back(mk(1,1,0,4'h0,  15, KICK,  1,1,0,0,4'h8));
      tab.push_back(mk(1,1,0,4'h0,   1, SETTLE,1,0,0,0,4'h8));
      tab.push_back(mk(1,1,0,4'h0,1023, SETTLE,1,0,0,0,4'h8));
      tab.push_back(mk(1,1,0,4'h0,   1, CHECK, 1,0,0,0,4'h8));
      tab.push_back(mk(1,1,0,4'h0,   7, CHECK, 1,0,0,0,4'h8));
      tab.push_back(mk(1,1,0,4'h0,   1, READY, 1,0,1,0,4'h8));
      tab.push_back(mk(1,1,1,4'hC,   1, SETTLE,1,0,0,0,4'hC));
      tab.push_back(mk(1,1,0,4'h0,1023, SETTLE,1,0,0,0,4'hC));
      tab.push_back(mk(1,1,0,4'h0,   1, CHECK, 1,0,0,0,4'hC));
      tab.push_back(mk(1,1,0,4'h0,   7, CHECK, 1,0,0,0,4'hC));
      tab.push_back(mk(1,1,0,4'h0,   1, READY, 1,0,1,0,4'hC));
      tab.push_back(mk(1,0,0,4'h0,   2, READY, 1,0,1,0,4'hC));
      tab.push_back(mk(1,0,0,4'h0,   7, READY, 1,0,1,0,4'hC));
      tab.push_back(mk(1,0,0,4'h0,   1, KICK,  1,1,0,0,4'hC));
      tab.push_back(mk(0,0,0,4'h0,   1, OFF,   0,0,0,0,4'hC));
      tab.push_back(mk(0,0,1,4'h5,   1, OFF,   0,0,0,0,4'hC));
      tab.push_back(mk(0,0,0,4'h0,   1, OFF,   0,0,0,0,4'h5));

      cmp_ok = 1'b1;
      do_reset();
      foreach (tab[i]) begin
         en_req    = tab[i].en;
         cmp_ok    = tab[i].cmp;
         trim_load = tab[i].tl;
         trim_in   = tab[i].ti;
         tick();
         trim_load = 1'b0;
         for (int k = 1; k < tab[i].n; k++) tick();
         chk($sformatf("vec%0d", i),
             {21'd0, state, bgr_en, bgr_start, ready, fault, trim_out},
             {21'd0, tab[i].st, tab[i].be, tab[i].bs, tab[i].rdy,
              tab[i].flt, tab[i].tr});
      end

      // never in window: three attempts then FAULT; trim loaded mid-SETTLE
      cmp_ok = 1'b0;
      do_reset();
      en_req = 1'b1;
      cyc = 0; pulses = 0; plen = 0; bad_len = 0;
      done = 0; saw_rdy = 0; early_flt = 0; trim_bad = 0;
      for (int i = 0; i < 5000 && !done; i++) begin
         tick();
         cyc++;
         if (cyc == 100) begin
            trim_in   = 4'h3;
            trim_load = 1'b1;
         end else begin
            trim_load = 1'b0;
         end
         if (bgr_start) plen++;
         else if (plen != 0) begin
            pulses++;
            if (plen != 16) bad_len++;
            plen = 0;
         end
         if (ready) saw_rdy = 1;
         if (trim_out !== 4'h8) trim_bad = 1;
         if (state === FAULT) done = 1;
         else if (fault) early_flt = 1;
      end
      trim_load = 1'b0;
      chk("fault_reached", 32'(done), 32'd1);
      chk("fault_latency", cyc, 3889);
      chk("kick_pulses", pulses, 3);
      chk("kick_len_bad", bad_len, 0);
      chk("ready_seen", 32'(saw_rdy), 32'd0);
      chk("fault_early", 32'(early_flt), 32'd0);
      chk("busy_trim_held", 32'(trim_bad), 32'd0);
      chk("fault_outs", {bgr_en, bgr_start, ready, fault}, 4'b0001);
      en_req = 1'b0;
      tick();
      chk("fault_to_off", {state, fault, bgr_en}, {OFF, 2'b00});
      tick();
      chk("off_trim_applied", trim_out, 4'h3);
      en_req = 1'b1;
      tick();
      chk("fresh_kick", {state, bgr_start}, {KICK, 1'b1});

      // glitch rejection in CHECK and READY, then reset mid-CHECK
      cmp_ok = 1'b0;
      do_reset();
      trim_in   = 4'h5;
      trim_load = 1'b1;
      tick();
      trim_load = 1'b0;
      tick();
      chk("off_trim5", trim_out, 4'h5);
      en_req = 1'b1;
      wait_state(CHECK, 1100, n);
      chk("check_entry", n, 1041);
      repeat (5) tick();
      cmp_ok = 1'b1;
      repeat (7) tick();
      cmp_ok = 1'b0;
      saw_rdy = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ready) saw_rdy = 1;
      end
      chk("check_glitch_rdy", 32'(saw_rdy), 32'd0);
      chk("check_glitch_st", state, CHECK);
      cmp_ok = 1'b1;
      wait_state(READY, 30, n);
      chk("ready_latency", n, 10);
      chk("ready_out", {ready, bgr_en, fault}, 3'b110);
      cmp_ok = 1'b0;
      repeat (7) tick();
      cmp_ok = 1'b1;
      saw_rdy = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (!ready) saw_rdy = 0;
      end
      chk("ready_glitch_held", 32'(saw_rdy), 32'd1);
      chk("ready_glitch_st", state, READY);
      cmp_ok = 1'b0;
      wait_state(KICK, 30, n);
      chk("loss_latency", n, 10);
      chk("loss_outs", {ready, bgr_start}, 2'b01);
      cmp_ok = 1'b1;
      wait_state(CHECK, 1100, n);
      chk("rekick_to_check", n, 1040);
      repeat (3) tick();
      chk("pre_reset_st", state, CHECK);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset",
          {state, bgr_en, bgr_start, ready, fault, trim_out},
          {OFF, 4'b0000, 4'h8});
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
